// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and defaults for the PC sequencer
package pc_sequencer_pkg;

  localparam int IMEM_ADDR_W_DEF = 10;
  localparam int START_PC_DEF    = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_BARRIER = 3'd3,
    ST_HALT    = 3'd4
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational branch/JALR target and link computation
module pc_target_calc
  import pc_sequencer_pkg::*;
#(
  parameter int IMEM_ADDR_W = IMEM_ADDR_W_DEF
) (
  input  logic [IMEM_ADDR_W-1:0] ex_pc_i,
  input  logic [IMEM_ADDR_W-1:0] br_offset_i,
  input  logic [31:0]            jalr_target_i,
  output logic [IMEM_ADDR_W-1:0] next_pc_o,
  output logic [IMEM_ADDR_W-1:0] branch_target_o,
  output logic [IMEM_ADDR_W-1:0] jalr_target_o,
  output logic [31:0]            link_o
);

  localparam logic [IMEM_ADDR_W-1:0] ONE = IMEM_ADDR_W'(1);

  // Only the low address bits of the JALR register value select a word.
  logic jalr_upper_unused;

  // All targets wrap modulo the instruction address space.
  assign next_pc_o         = ex_pc_i + ONE;
  assign branch_target_o   = next_pc_o + br_offset_i;
  assign jalr_target_o     = jalr_target_i[IMEM_ADDR_W-1:0];
  assign jalr_upper_unused = ^jalr_target_i[31:IMEM_ADDR_W];

  // Link value is computed at full width so it does not wrap at the top word.
  assign link_o = {{(32-IMEM_ADDR_W){1'b0}}, ex_pc_i} + 32'd1;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register and fetch/redirect/barrier/halt sequencing FSM
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int IMEM_ADDR_W = IMEM_ADDR_W_DEF,
  parameter int START_PC    = START_PC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   fetch_ready_i,
  input  logic                   stall_i,
  input  logic                   ex_valid_i,
  input  logic [IMEM_ADDR_W-1:0] ex_pc_i,
  input  logic                   is_branch_i,
  input  logic                   jump_now_i,
  input  logic [IMEM_ADDR_W-1:0] br_offset_i,
  input  logic                   is_jalr_i,
  input  logic [31:0]            jalr_target_i,
  input  logic                   is_bar_i,
  input  logic                   barrier_release_i,
  input  logic                   is_done_i,
  output logic [IMEM_ADDR_W-1:0] pc_o,
  output logic                   fetch_valid_o,
  output logic                   flush_o,
  output logic [31:0]            link_o,
  output logic                   barrier_o,
  output logic                   halted_o
);

  localparam logic [IMEM_ADDR_W-1:0] START_ADDR = IMEM_ADDR_W'(START_PC);
  localparam logic [IMEM_ADDR_W-1:0] ONE        = IMEM_ADDR_W'(1);

  pc_state_e              state_q, state_d;
  logic [IMEM_ADDR_W-1:0] pc_q, pc_d;
  logic [IMEM_ADDR_W-1:0] next_pc, branch_target, jalr_target;
  logic                   accept, redirect;

  pc_target_calc #(
    .IMEM_ADDR_W(IMEM_ADDR_W)
  ) u_target (
    .ex_pc_i        (ex_pc_i),
    .br_offset_i    (br_offset_i),
    .jalr_target_i  (jalr_target_i),
    .next_pc_o      (next_pc),
    .branch_target_o(branch_target),
    .jalr_target_o  (jalr_target),
    .link_o         (link_o)
  );

  // jump_now_i is gated by is_branch_i so its value is irrelevant for non-branches.
  assign accept   = ex_valid_i & ~stall_i;
  assign redirect = (is_branch_i & jump_now_i) | is_jalr_i;

  // State and PC registers; async reset returns to IDLE at START_PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= START_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and next PC; priority in RUN is done > redirect > barrier > sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
        end
      end
      ST_RUN: begin
        if (accept & is_done_i) begin
          state_d = ST_HALT;
        end else if (accept & redirect) begin
          state_d = ST_FLUSH;
          pc_d    = is_jalr_i ? jalr_target : branch_target;
        end else if (accept & is_bar_i) begin
          state_d = ST_BARRIER;
          pc_d    = next_pc;
        end else if (fetch_ready_i & ~stall_i) begin
          pc_d = pc_q + ONE;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      ST_BARRIER: begin
        if (barrier_release_i) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = START_ADDR;
      end
    endcase
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = (state_q == ST_RUN);
  assign flush_o       = (state_q == ST_FLUSH);
  assign barrier_o     = (state_q == ST_BARRIER);
  assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with a reference model
module tb_pc_sequencer;

  localparam int AW  = 10;
  localparam int NPC = 1 << AW;
  localparam int SPC = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i, fetch_ready_i, stall_i, ex_valid_i;
  logic [AW-1:0] ex_pc_i, br_offset_i;
  logic          is_branch_i, jump_now_i, is_jalr_i, is_bar_i, barrier_release_i, is_done_i;
  logic [31:0]   jalr_target_i;
  logic [AW-1:0] pc_o;
  logic          fetch_valid_o, flush_o, barrier_o, halted_o;
  logic [31:0]   link_o;

  pc_sequencer #(.IMEM_ADDR_W(AW), .START_PC(SPC)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .fetch_ready_i    (fetch_ready_i),
    .stall_i          (stall_i),
    .ex_valid_i       (ex_valid_i),
    .ex_pc_i          (ex_pc_i),
    .is_branch_i      (is_branch_i),
    .jump_now_i       (jump_now_i),
    .br_offset_i      (br_offset_i),
    .is_jalr_i        (is_jalr_i),
    .jalr_target_i    (jalr_target_i),
    .is_bar_i         (is_bar_i),
    .barrier_release_i(barrier_release_i),
    .is_done_i        (is_done_i),
    .pc_o             (pc_o),
    .fetch_valid_o    (fetch_valid_o),
    .flush_o          (flush_o),
    .link_o           (link_o),
    .barrier_o        (barrier_o),
    .halted_o         (halted_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          start, ready, stall, exv, br, jn, jalr, bar, rel, done;
    int          expc;
    int          off;
    logic [31:0] jt;
  } stim_t;

  typedef struct {
    int pc;
    bit fv, fl, ba, ha;
  } exp_t;

  exp_t q[$];
  int vectors    = 0;
  int miscompares = 0;

  // Reference model: which activity the core is engaged in, plus the fetch address.
  int m_pc;
  bit m_running, m_flushing, m_waiting, m_halted;

  task automatic check(string name, longint act, longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int wrap(int x);
    return ((x % NPC) + NPC) % NPC;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.pc = m_pc; e.fv = m_running; e.fl = m_flushing; e.ba = m_waiting; e.ha = m_halted;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = SPC; m_running = 0; m_flushing = 0; m_waiting = 0; m_halted = 0;
  endtask

  task automatic model_step(stim_t s);
    bit take;
    take = s.exv && !s.stall;
    if (m_flushing) begin
      m_flushing = 0; m_running = 1;
    end else if (m_waiting) begin
      if (s.rel) begin m_waiting = 0; m_running = 1; end
    end else if (m_running) begin
      if (take && s.done) begin
        m_running = 0; m_halted = 1;
      end else if (take && s.jalr) begin
        m_pc = int'(s.jt % NPC); m_running = 0; m_flushing = 1;
      end else if (take && s.br && s.jn) begin
        m_pc = wrap(s.expc + 1 + s.off); m_running = 0; m_flushing = 1;
      end else if (take && s.bar) begin
        m_pc = wrap(s.expc + 1); m_running = 0; m_waiting = 1;
      end else if (s.ready && !s.stall) begin
        m_pc = wrap(m_pc + 1);
      end
    end else if (s.start) begin
      m_halted = 0; m_running = 1; m_pc = SPC;
    end
  endtask

  task automatic drive(stim_t s);
    start_i = s.start; fetch_ready_i = s.ready; stall_i = s.stall; ex_valid_i = s.exv;
    ex_pc_i = s.expc[AW-1:0]; is_branch_i = s.br; jump_now_i = s.jn; br_offset_i = s.off[AW-1:0];
    is_jalr_i = s.jalr; jalr_target_i = s.jt; is_bar_i = s.bar;
    barrier_release_i = s.rel; is_done_i = s.done;
  endtask

  // Called just after a rising edge: drive, predict the next cycle, then advance.
  task automatic apply(stim_t s);
    drive(s);
    model_step(s);
    q.push_back(cur_exp());
    #1;
    check("link", link_o, longint'(s.expc) + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    drive(idle_stim());
    model_reset();
    #1;
    check("async_reset_pc", pc_o, SPC);
    check("async_reset_fv", fetch_valid_o, 0);
    q.push_back(cur_exp());
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: each falling edge the DUT presents one cycle's outputs to compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc_o", pc_o, e.pc);
        check("fetch_valid_o", fetch_valid_o, e.fv);
        check("flush_o", flush_o, e.fl);
        check("barrier_o", barrier_o, e.ba);
        check("halted_o", halted_o, e.ha);
      end
    end
  end

  initial begin
    stim_t s;
    int op;
    reset = 1'b1;
    drive(idle_stim());
    model_reset();
    q.push_back(cur_exp());
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Start and sequential fetch.
    s = idle_stim(); s.start = 1; s.ready = 1; apply(s);
    s = idle_stim(); s.ready = 1;
    for (int i = 0; i < 4; i++) apply(s);

    // Taken branch backwards, then not-taken, then non-branch with jump_now high.
    s = idle_stim(); s.ready = 1; s.exv = 1; s.expc = 5; s.br = 1; s.jn = 1; s.off = -3; apply(s);
    s = idle_stim(); s.ready = 1; apply(s);
    s = idle_stim(); s.ready = 1; s.exv = 1; s.expc = 5; s.br = 1; s.jn = 0; s.off = -3; apply(s);
    s = idle_stim(); s.ready = 1; s.exv = 1; s.expc = 5; s.br = 0; s.jn = 1; s.off = -3; apply(s);

    // JALR with upper bits set.
    s = idle_stim(); s.ready = 1; s.exv = 1; s.expc = 7; s.jalr = 1; s.jt = 32'hFFFF_F404; apply(s);
    s = idle_stim(); s.ready = 1; apply(s);

    // Branch target wraps at the top of the address space; stalled branch is ignored.
    s = idle_stim(); s.ready = 1; s.exv = 1; s.expc = 1023; s.br = 1; s.jn = 1; s.off = 0; apply(s);
    s = idle_stim(); s.ready = 1; apply(s);
    s = idle_stim(); s.ready = 1; s.stall = 1; s.exv = 1; s.expc = 40; s.br = 1; s.jn = 1; s.off = 9; apply(s);

    // Barrier: release on the entry cycle is ignored, later release exits.
    s = idle_stim(); s.ready = 1; s.exv = 1; s.expc = 12; s.bar = 1; s.rel = 1; apply(s);
    s = idle_stim(); s.ready = 1; apply(s); apply(s);
    s.rel = 1; apply(s);
    s = idle_stim(); s.ready = 1; apply(s);

    // DONE outranks a taken branch; reset during HALT; restart.
    s = idle_stim(); s.ready = 1; s.exv = 1; s.expc = 20; s.done = 1; s.br = 1; s.jn = 1; s.off = 4; apply(s);
    s = idle_stim(); s.ready = 1; apply(s);
    do_reset();
    s = idle_stim(); s.start = 1; s.ready = 1; apply(s);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      s = idle_stim();
      s.start = ($urandom_range(0, 9) == 0);
      s.ready = ($urandom_range(0, 3) != 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.exv   = ($urandom_range(0, 4) < 3);
      s.expc  = int'($urandom_range(0, NPC - 1));
      s.off   = int'($urandom_range(0, NPC - 1)) - NPC / 2;
      s.jt    = $urandom;
      s.jn    = $urandom_range(0, 1) == 1;
      s.rel   = ($urandom_range(0, 2) == 0);
      op = int'($urandom_range(0, 11));
      case (op)
        0, 1, 2: s.br = 1;
        3:       s.jalr = 1;
        4:       s.bar = 1;
        5:       s.done = ($urandom_range(0, 2) == 0);
        6:       begin s.done = ($urandom_range(0, 2) == 0); s.br = 1; end
        default: ;
      endcase
      apply(s);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
